// File: rtl/alu_fault_manager_pkg.sv
// Shared fault-tolerance constants for the redundant execute ALU: controller state
// encoding and default escalation threshold / counter width.
package alu_fault_manager_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    RETRY  = 2'b01,
    SWITCH = 2'b10,
    HALT   = 2'b11
  } fmState_e;

  localparam int FAULT_THRESH_DEFAULT = 3;
  localparam int CNT_W_DEFAULT        = 8;

endpackage

// File: rtl/alu_fault_manager_if.sv
// Bundle between the EX stage / redundant ALU and the fault manager, plus status and
// a debug view of the controller state.
interface alu_fault_manager_if #(
  parameter int FAULT_THRESH = alu_fault_manager_pkg::FAULT_THRESH_DEFAULT,
  parameter int CNT_W        = alu_fault_manager_pkg::CNT_W_DEFAULT
);
  import alu_fault_manager_pkg::*;

  localparam int CONSEC_W = $clog2(FAULT_THRESH + 1);

  // Handshake: ex_valid qualifies alu_done/alu_fault (both ignored while ex_valid=0);
  // an op leaves EX on a cycle where ex_valid=1 and stall=0, stall acting as not-ready.
  logic                ex_valid;
  logic                alu_done;
  logic                alu_fault;
  logic                clear_cnt;
  logic                stall;
  logic                alu_restart;
  logic                spare_sel;
  logic [CONSEC_W-1:0] consec_count;
  logic [CNT_W-1:0]    fault_count;
  logic                fault_irq;
  logic                halted;
  fmState_e            state;

  modport master (
    output ex_valid, alu_done, alu_fault, clear_cnt,
    input  stall, alu_restart, spare_sel, consec_count, fault_count, fault_irq, halted, state
  );

  modport slave (
    input  ex_valid, alu_done, alu_fault, clear_cnt,
    output stall, alu_restart, spare_sel, consec_count, fault_count, fault_irq, halted, state
  );

endinterface

// File: rtl/alu_fault_manager_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an increment
// leaves the count at 1 so that event is not lost.
module fault_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_fault_manager.sv
// Pipeline-side controller for the time-redundant ALU: stalls EX until an op is
// validated, counts faults and escalates primary -> spare -> halt.
module alu_fault_manager
  import alu_fault_manager_pkg::*;
#(
  parameter int FAULT_THRESH = FAULT_THRESH_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  alu_fault_manager_if.slave bus
);

  localparam int                  CONSEC_W = $clog2(FAULT_THRESH + 1);
  localparam logic [CONSEC_W-1:0] LAST_OK  = CONSEC_W'(FAULT_THRESH - 1);

  fmState_e            state;
  logic [CONSEC_W-1:0] consec;
  logic                active;
  logic                faultEv;
  logic                doneEv;
  logic                atThresh;
  logic                doneAcc;
  logic                stallC;
  logic                restartQ;
  logic                spareQ;
  logic                haltedQ;
  logic                irqQ;

  assign active   = (state == RUN) || (state == RETRY);
  assign faultEv  = active & bus.ex_valid & bus.alu_fault;
  assign doneEv   = active & bus.ex_valid & bus.alu_done;
  assign atThresh = faultEv && (consec == LAST_OK);
  // A done that coincides with the escalating fault is dropped: the op re-runs elsewhere.
  assign doneAcc  = doneEv & ~atThresh;

  always_comb begin
    stallC = 1'b1;
    case (state)
      RUN:     stallC = bus.ex_valid & ~doneAcc;
      RETRY:   stallC = ~doneAcc;
      default: stallC = 1'b1;
    endcase
  end

  assign bus.stall = rst & stallC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      restartQ <= 1'b0;
      spareQ   <= 1'b0;
      haltedQ  <= 1'b0;
      irqQ     <= 1'b0;
    end else begin
      irqQ     <= faultEv;
      restartQ <= 1'b0;
      case (state)
        RUN, RETRY: begin
          if (faultEv) begin
            if (atThresh) begin
              if (spareQ) begin
                state   <= HALT;
                haltedQ <= 1'b1;
              end else begin
                state    <= SWITCH;
                restartQ <= 1'b1;
              end
            end else begin
              state <= doneEv ? RUN : RETRY;
            end
          end else if (doneEv) begin
            state <= RUN;
          end
        end
        SWITCH: begin
          state  <= RUN;
          spareQ <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

  fault_sat_counter #(.W(CONSEC_W)) u_consec (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == SWITCH) | (doneEv & ~faultEv)),
    .inc   (faultEv),
    .count (consec)
  );

  fault_sat_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.clear_cnt),
    .inc   (faultEv),
    .count (bus.fault_count)
  );

  assign bus.alu_restart  = restartQ;
  assign bus.spare_sel    = spareQ;
  assign bus.halted       = haltedQ;
  assign bus.fault_irq    = irqQ;
  assign bus.consec_count = consec;
  assign bus.state        = state;

endmodule

// File: tb/tb_alu_fault_manager.sv
// Directed bench for alu_fault_manager: an abstract per-cycle model plus hand-computed
// checkpoints; a second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_alu_fault_manager;
  import alu_fault_manager_pkg::*;

  localparam int THRESH = 3;

  logic clk;
  logic rst;
  int   nChk;
  int   nFail;

  alu_fault_manager_if #(.FAULT_THRESH(THRESH), .CNT_W(8)) mainIf ();
  alu_fault_manager_if #(.FAULT_THRESH(THRESH), .CNT_W(2)) satIf ();

  assign satIf.ex_valid  = mainIf.ex_valid;
  assign satIf.alu_done  = mainIf.alu_done;
  assign satIf.alu_fault = mainIf.alu_fault;
  assign satIf.clear_cnt = mainIf.clear_cnt;

  alu_fault_manager #(.FAULT_THRESH(THRESH), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mainIf)
  );

  alu_fault_manager #(.FAULT_THRESH(THRESH), .CNT_W(2)) dutSat (
    .clk (clk),
    .rst (rst),
    .bus (satIf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs just after the edge, return mid-cycle once outputs settle
  task automatic cyc(input logic ev, input logic done, input logic flt, input logic clr);
    @(posedge clk);
    #1;
    mainIf.ex_valid  = ev;
    mainIf.alu_done  = done;
    mainIf.alu_fault = flt;
    mainIf.clear_cnt = clr;
    @(negedge clk);
    #1;
  endtask

  // behavioural model: booleans for "retrying", "switching", "halted" and plain counts
  int mConsec;
  int mTotal;
  bit mRetry;
  bit mSwitch;
  bit mHalt;
  bit mSpare;
  bit mIrq;

  always @(negedge clk) begin
    bit counted;
    bit doneSeen;
    bit escalate;
    bit accepted;
    bit expStall;
    if (!rst) begin
      mConsec = 0; mTotal = 0; mRetry = 0; mSwitch = 0; mHalt = 0; mSpare = 0; mIrq = 0;
      cmp("rst_stall",   32'(mainIf.stall),        0);
      cmp("rst_restart", 32'(mainIf.alu_restart),  0);
      cmp("rst_spare",   32'(mainIf.spare_sel),    0);
      cmp("rst_consec",  32'(mainIf.consec_count), 0);
      cmp("rst_count",   32'(mainIf.fault_count),  0);
      cmp("rst_irq",     32'(mainIf.fault_irq),    0);
      cmp("rst_halted",  32'(mainIf.halted),       0);
    end else begin
      counted  = !mSwitch && !mHalt && mainIf.ex_valid && mainIf.alu_fault;
      doneSeen = !mSwitch && !mHalt && mainIf.ex_valid && mainIf.alu_done;
      escalate = counted && (mConsec + 1 == THRESH);
      accepted = doneSeen && !escalate;
      if (mSwitch || mHalt) expStall = 1'b1;
      else if (mRetry)      expStall = !accepted;
      else                  expStall = mainIf.ex_valid && !accepted;

      cmp("m_stall",     32'(mainIf.stall),        32'(expStall));
      cmp("m_restart",   32'(mainIf.alu_restart),  32'(mSwitch));
      cmp("m_spare",     32'(mainIf.spare_sel),    32'(mSpare));
      cmp("m_consec",    32'(mainIf.consec_count), 32'(mConsec));
      cmp("m_count",     32'(mainIf.fault_count),  32'(mTotal > 255 ? 255 : mTotal));
      cmp("m_count_sat", 32'(satIf.fault_count),   32'(mTotal > 3 ? 3 : mTotal));
      cmp("m_irq",       32'(mainIf.fault_irq),    32'(mIrq));
      cmp("m_halted",    32'(mainIf.halted),       32'(mHalt));

      mIrq   = counted;
      mTotal = mainIf.clear_cnt ? int'(counted) : mTotal + int'(counted);
      if (mSwitch) begin
        mSwitch = 0; mSpare = 1; mConsec = 0;
      end else if (counted) begin
        mConsec++;
        if (mConsec == THRESH) begin
          mRetry = 0;
          if (mSpare) mHalt = 1;
          else        mSwitch = 1;
        end else begin
          mRetry = !doneSeen;
        end
      end else if (doneSeen) begin
        mConsec = 0;
        mRetry  = 0;
      end
    end
  end

  initial begin
    nChk  = 0;
    nFail = 0;
    rst   = 1'b0;
    mainIf.ex_valid  = 1'b0;
    mainIf.alu_done  = 1'b0;
    mainIf.alu_fault = 1'b0;
    mainIf.clear_cnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("reset_state", 32'(mainIf.state), 32'(RUN));
    @(posedge clk);
    #1 rst = 1'b1;

    // fault-free op: one stall cycle, counters untouched
    cyc(1, 0, 0, 0); cmp("ff_stall_wait", 32'(mainIf.stall), 1);
    cyc(1, 1, 0, 0); cmp("ff_stall_done", 32'(mainIf.stall), 0);
    cyc(0, 0, 0, 0); cmp("ff_count", 32'(mainIf.fault_count), 0);

    // single fault then retry completes
    cyc(1, 0, 1, 0); cmp("sf_stall", 32'(mainIf.stall), 1);
    cyc(1, 1, 0, 0); cmp("sf_irq", 32'(mainIf.fault_irq), 1);
                     cmp("sf_count", 32'(mainIf.fault_count), 1);
                     cmp("sf_consec", 32'(mainIf.consec_count), 1);
    cyc(0, 0, 0, 0); cmp("sf_consec_clr", 32'(mainIf.consec_count), 0);
                     cmp("sf_spare", 32'(mainIf.spare_sel), 0);

    // ex_valid=0 inputs ignored
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0); cmp("ign_count", 32'(mainIf.fault_count), 1);

    // fault + done together below threshold -> RUN
    cyc(1, 1, 1, 0); cmp("fd_stall", 32'(mainIf.stall), 0);
    cyc(0, 0, 0, 0); cmp("fd_state", 32'(mainIf.state), 32'(RUN));
                     cmp("fd_count", 32'(mainIf.fault_count), 2);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0); cmp("fd_consec", 32'(mainIf.consec_count), 0);

    // clear coincident with fault -> 1, then plain clear -> 0
    cyc(1, 0, 1, 1);
    cyc(1, 1, 0, 0); cmp("clr_fault", 32'(mainIf.fault_count), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); cmp("clr_only", 32'(mainIf.fault_count), 0);

    // escalation to spare
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); cmp("esc_consec2", 32'(mainIf.consec_count), 2);
    cyc(1, 0, 1, 0); cmp("esc_restart", 32'(mainIf.alu_restart), 1);
                     cmp("esc_state", 32'(mainIf.state), 32'(SWITCH));
    cyc(1, 0, 0, 0); cmp("esc_spare", 32'(mainIf.spare_sel), 1);
                     cmp("esc_consec0", 32'(mainIf.consec_count), 0);
                     cmp("esc_count", 32'(mainIf.fault_count), 3);
                     cmp("esc_restart_off", 32'(mainIf.alu_restart), 0);

    // spare exhaustion
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); cmp("ex_count5", 32'(mainIf.fault_count), 5);
                     cmp("ex_sat", 32'(satIf.fault_count), 3);
    cyc(1, 0, 1, 0); cmp("ex_halted", 32'(mainIf.halted), 1);
                     cmp("ex_count6", 32'(mainIf.fault_count), 6);
    cyc(1, 1, 0, 0); cmp("ex_stall", 32'(mainIf.stall), 1);
    cyc(0, 0, 0, 0); cmp("ex_stall_idle", 32'(mainIf.stall), 1);
                     cmp("ex_count_hold", 32'(mainIf.fault_count), 6);

    // reset in the middle of SWITCH
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0); cmp("rs_halted", 32'(mainIf.halted), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); cmp("rs_in_switch", 32'(mainIf.alu_restart), 1);
    #1 rst = 1'b0;
    #1;
    cmp("rs_restart", 32'(mainIf.alu_restart), 0);
    cmp("rs_spare",   32'(mainIf.spare_sel), 0);
    cmp("rs_stall",   32'(mainIf.stall), 0);
    cmp("rs_count",   32'(mainIf.fault_count), 0);
    cmp("rs_state",   32'(mainIf.state), 32'(RUN));
    cyc(0, 0, 0, 0); cmp("rs_spare_hold", 32'(mainIf.spare_sel), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 0, 0, 0); cmp("rs_after_spare", 32'(mainIf.spare_sel), 0);
                     cmp("rs_after_restart", 32'(mainIf.alu_restart), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
